// File: rtl/link_control.sv
// link_control
// ------------
// Initiator-side control FSM for the Link character datapath. The block
// samples the debounced player keys once per video frame, issues exactly one
// action pulse for that frame, and then holds draw_char until the datapath
// reports draw_done. A watchdog aborts a draw that never completes.
//
// Parameters
//   ATTACK_FRAMES  consecutive frames an attack lasts once started (>= 1)
//   DRAW_TIMEOUT   max clock cycles in the draw state without draw_done (>= 4)
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   frame_tick     one-cycle pulse per video frame
//   key_*          debounced, active-high player keys
//   draw_done      level from datapath, high when the sprite draw completed
//   init           one-cycle pulse, place character at spawn
//   idle           one-cycle pulse, no movement this frame
//   attack         one-cycle pulse, attack step this frame
//   move_*         one-cycle move pulses
//   draw_char      held high while the datapath draws
//   attack_active  high while an attack sequence is in progress
//   frame_overrun  sticky, a frame_tick arrived outside S_IDLE
//   draw_timeout   sticky, a draw was aborted by the watchdog
//   state_dbg      current state encoding
module link_control #(
  parameter int ATTACK_FRAMES = 8,
  parameter int DRAW_TIMEOUT  = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  input  logic       draw_done,
  output logic       init,
  output logic       idle,
  output logic       attack,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       draw_char,
  output logic       attack_active,
  output logic       frame_overrun,
  output logic       draw_timeout,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_DRAW  = 3'd2;
  localparam logic [2:0] S_IDLE  = 3'd3;
  localparam logic [2:0] S_ACT   = 3'd4;

  localparam int DCW = $clog2(DRAW_TIMEOUT);
  localparam int ACW = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;

  localparam logic [DCW-1:0] DRAW_LAST = DCW'(DRAW_TIMEOUT - 1);
  localparam logic [ACW-1:0] ATK_LOAD  = ACW'(ATTACK_FRAMES - 1);
  localparam logic           ATK_MULTI = (ATTACK_FRAMES > 1) ? 1'b1 : 1'b0;

  logic [2:0]     state_q, state_d;
  logic [DCW-1:0] draw_cnt_q, draw_cnt_d;
  logic [ACW-1:0] atk_cnt_q, atk_cnt_d;
  logic           atk_act_q, atk_act_d;
  logic           init_q, init_d;
  logic           idle_q, idle_d;
  logic           attack_q, attack_d;
  logic           up_q, up_d;
  logic           down_q, down_d;
  logic           left_q, left_d;
  logic           right_q, right_d;
  logic           draw_q, draw_d;
  logic           overrun_q, overrun_d;
  logic           timeout_q, timeout_d;

  logic vert_sel, horiz_sel;

  // Opposite keys held together cancel their axis.
  assign vert_sel  = key_up ^ key_down;
  assign horiz_sel = key_left ^ key_right;

  // Every output register is loaded from the *next* state, so each output is
  // high exactly while the FSM sits in the matching state. Because of that the
  // action decision is taken on the frame_tick edge from the live keys: the
  // pulse flops themselves hold the per-frame key snapshot, which keeps the
  // tick-to-pulse latency at one cycle.
  always_comb begin
    state_d    = state_q;
    draw_cnt_d = draw_cnt_q;
    atk_cnt_d  = atk_cnt_q;
    atk_act_d  = atk_act_q;
    init_d     = 1'b0;
    idle_d     = 1'b0;
    attack_d   = 1'b0;
    up_d       = 1'b0;
    down_d     = 1'b0;
    left_d     = 1'b0;
    right_d    = 1'b0;
    draw_d     = 1'b0;
    timeout_d  = timeout_q;
    // A tick that is not taken in S_IDLE is dropped, never queued. This also
    // covers a tick on the very cycle the FSM is still leaving S_DRAW.
    overrun_d  = overrun_q | (frame_tick && (state_q != S_IDLE));

    case (state_q)
      S_RESET: begin
        state_d = S_INIT;
        init_d  = 1'b1;
      end

      S_INIT: begin
        // The spawn sprite is drawn right away, without waiting for a tick.
        state_d    = S_DRAW;
        draw_cnt_d = '0;
        draw_d     = 1'b1;
      end

      S_DRAW: begin
        // draw_cnt_q == 0 marks the first draw cycle, where draw_done may
        // still be the stale level left over from the previous draw.
        if ((draw_cnt_q != '0) && draw_done) begin
          state_d = S_IDLE;
        end else if (draw_cnt_q == DRAW_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          draw_cnt_d = draw_cnt_q + DCW'(1);
          draw_d     = 1'b1;
        end
      end

      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_ACT;
          if (atk_act_q) begin
            // An attack in progress ignores all key changes.
            attack_d  = 1'b1;
            atk_cnt_d = atk_cnt_q - ACW'(1);
            if (atk_cnt_q == ACW'(1)) begin
              atk_act_d = 1'b0;
            end
          end else if (key_attack) begin
            attack_d  = 1'b1;
            atk_cnt_d = ATK_LOAD;
            atk_act_d = ATK_MULTI;
          end else if (vert_sel) begin
            up_d   = key_up;
            down_d = key_down;
          end else if (horiz_sel) begin
            left_d  = key_left;
            right_d = key_right;
          end else begin
            idle_d = 1'b1;
          end
        end
      end

      S_ACT: begin
        state_d    = S_DRAW;
        draw_cnt_d = '0;
        draw_d     = 1'b1;
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RESET;
      draw_cnt_q <= '0;
      atk_cnt_q  <= '0;
      atk_act_q  <= 1'b0;
      init_q     <= 1'b0;
      idle_q     <= 1'b0;
      attack_q   <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      draw_q     <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      draw_cnt_q <= draw_cnt_d;
      atk_cnt_q  <= atk_cnt_d;
      atk_act_q  <= atk_act_d;
      init_q     <= init_d;
      idle_q     <= idle_d;
      attack_q   <= attack_d;
      up_q       <= up_d;
      down_q     <= down_d;
      left_q     <= left_d;
      right_q    <= right_d;
      draw_q     <= draw_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign init          = init_q;
  assign idle          = idle_q;
  assign attack        = attack_q;
  assign move_up       = up_q;
  assign move_down     = down_q;
  assign move_left     = left_q;
  assign move_right    = right_q;
  assign draw_char     = draw_q;
  assign attack_active = atk_act_q;
  assign frame_overrun = overrun_q;
  assign draw_timeout  = timeout_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_link_control.sv
// Directed testbench for link_control (ATTACK_FRAMES=8, DRAW_TIMEOUT=256).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_link_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       key_up, key_down, key_left, key_right, key_attack;
  logic       draw_done;
  logic       init, idle, attack;
  logic       move_up, move_down, move_left, move_right;
  logic       draw_char, attack_active, frame_overrun, draw_timeout;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // Pulse encodings: {init, idle, attack, up, down, left, right}
  localparam logic [6:0] P_NONE  = 7'b0000000;
  localparam logic [6:0] P_INIT  = 7'b1000000;
  localparam logic [6:0] P_IDLE  = 7'b0100000;
  localparam logic [6:0] P_ATK   = 7'b0010000;
  localparam logic [6:0] P_UP    = 7'b0001000;
  localparam logic [6:0] P_DOWN  = 7'b0000100;
  localparam logic [6:0] P_LEFT  = 7'b0000010;
  localparam logic [6:0] P_RIGHT = 7'b0000001;

  // Key encodings: {up, down, left, right, attack}
  localparam logic [4:0] K_NONE  = 5'b00000;
  localparam logic [4:0] K_UP    = 5'b10000;
  localparam logic [4:0] K_DOWN  = 5'b01000;
  localparam logic [4:0] K_LEFT  = 5'b00100;
  localparam logic [4:0] K_UDR   = 5'b11010;
  localparam logic [4:0] K_ATK   = 5'b00001;

  logic [6:0]  pulses;
  logic [13:0] all_o;

  assign pulses = {init, idle, attack, move_up, move_down, move_left, move_right};
  assign all_o  = {pulses, draw_char, attack_active, frame_overrun, draw_timeout, state_dbg};

  link_control #(
    .ATTACK_FRAMES(8),
    .DRAW_TIMEOUT (256)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_attack   (key_attack),
    .draw_done    (draw_done),
    .init         (init),
    .idle         (idle),
    .attack       (attack),
    .move_up      (move_up),
    .move_down    (move_down),
    .move_left    (move_left),
    .move_right   (move_right),
    .draw_char    (draw_char),
    .attack_active(attack_active),
    .frame_overrun(frame_overrun),
    .draw_timeout (draw_timeout),
    .state_dbg    (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_keys(input logic [4:0] k);
    {key_up, key_down, key_left, key_right, key_attack} = k;
  endtask

  // One full frame from S_IDLE: tick, action pulse, two-cycle draw with
  // draw_done held high from the first draw cycle, back to S_IDLE.
  task automatic do_frame(input string tag, input logic [4:0] k,
                          input logic [6:0] exp_p, input logic exp_act);
    chk({tag, "_pre_idle"}, 32'(state_dbg), 32'd3);
    set_keys(k);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    set_keys(K_NONE);
    chk({tag, "_state_act"}, 32'(state_dbg), 32'd4);
    chk({tag, "_pulse"}, 32'(pulses), 32'(exp_p));
    chk({tag, "_atk_active"}, 32'(attack_active), 32'(exp_act));
    chk({tag, "_no_draw_in_act"}, 32'(draw_char), 32'd0);
    tick();
    chk({tag, "_draw1"}, 32'({state_dbg, draw_char, pulses}), 32'({3'd2, 1'b1, P_NONE}));
    draw_done = 1'b1;
    tick();
    // draw_done on the first draw cycle is ignored
    chk({tag, "_draw2"}, 32'({state_dbg, draw_char}), 32'({3'd2, 1'b1}));
    tick();
    chk({tag, "_back_idle"}, 32'({state_dbg, draw_char, pulses}), 32'({3'd3, 1'b0, P_NONE}));
    draw_done = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    frame_tick = 1'b0;
    draw_done  = 1'b0;
    set_keys(K_NONE);

    // Reset state
    tick();
    tick();
    chk("reset_outputs", 32'(all_o), 32'd0);

    // Release reset: init pulse, then draw of the spawn sprite
    reset = 1'b1;
    tick();
    chk("init_state", 32'(state_dbg), 32'd1);
    chk("init_pulse", 32'(pulses), 32'(P_INIT));
    chk("init_no_draw", 32'(draw_char), 32'd0);
    tick();
    chk("init_draw_start", 32'({state_dbg, draw_char, pulses}), 32'({3'd2, 1'b1, P_NONE}));
    for (int i = 0; i < 10; i++) tick();
    chk("init_draw_held", 32'({state_dbg, draw_char}), 32'({3'd2, 1'b1}));
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    chk("init_to_idle", 32'(all_o), 32'({P_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3}));
    tick();
    chk("idle_stays", 32'(all_o), 32'({P_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3}));

    // Movement decisions
    do_frame("left",   K_LEFT, P_LEFT,  1'b0);
    do_frame("udr",    K_UDR,  P_RIGHT, 1'b0);
    do_frame("up",     K_UP,   P_UP,    1'b0);
    do_frame("down",   K_DOWN, P_DOWN,  1'b0);
    do_frame("nokeys", K_NONE, P_IDLE,  1'b0);

    // Attack lasting 8 frames; key_up during the attack is ignored
    do_frame("atk1", K_ATK, P_ATK, 1'b1);
    for (int f = 2; f <= 8; f++) begin
      do_frame($sformatf("atk%0d", f), (f == 3) ? K_UP : K_NONE, P_ATK, (f < 8) ? 1'b1 : 1'b0);
    end
    do_frame("atk_after", K_NONE, P_IDLE, 1'b0);

    // Watchdog: draw_done never arrives
    chk("timeout_clear", 32'(draw_timeout), 32'd0);
    set_keys(K_DOWN);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    set_keys(K_NONE);
    chk("wd_pulse", 32'(pulses), 32'(P_DOWN));
    tick();
    chk("wd_draw_start", 32'({state_dbg, draw_char}), 32'({3'd2, 1'b1}));
    for (int i = 0; i < 255; i++) tick();
    chk("wd_last_cycle", 32'({state_dbg, draw_char, draw_timeout}), 32'({3'd2, 1'b1, 1'b0}));
    tick();
    chk("wd_abort", 32'({state_dbg, draw_char, draw_timeout}), 32'({3'd3, 1'b0, 1'b1}));
    do_frame("after_wd", K_LEFT, P_LEFT, 1'b0);
    chk("timeout_sticky", 32'(draw_timeout), 32'd1);

    // Overrun: frame_tick during a draw
    chk("overrun_clear", 32'(frame_overrun), 32'd0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("ovr_first_pulse", 32'(pulses), 32'(P_IDLE));
    tick();
    chk("ovr_in_draw", 32'(state_dbg), 32'd2);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("ovr_flag", 32'(frame_overrun), 32'd1);
    chk("ovr_no_pulse", 32'({state_dbg, draw_char, pulses}), 32'({3'd2, 1'b1, P_NONE}));
    tick();
    chk("ovr_still_draw", 32'({state_dbg, pulses}), 32'({3'd2, P_NONE}));

    // Asynchronous reset mid-draw
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 32'(all_o), 32'd0);
    @(negedge clock);
    chk("reset_held", 32'(all_o), 32'd0);
    reset = 1'b1;
    tick();
    chk("reinit", 32'({state_dbg, pulses, attack_active, frame_overrun, draw_timeout}),
        32'({3'd1, P_INIT, 1'b0, 1'b0, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
